// File: rtl/nibble_serial_addsub_16bit.sv
// Signed add/subtract of WIDTH bits through one 4-bit slice, one nibble per clock, LSB first.
// Optional SATURATE_EN clamps the result on signed overflow; flag_v reports overflow either way.
module nibble_serial_addsub_16bit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             dbg_state
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = $clog2(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    // Handshake: start is taken on any edge where busy==0 (including the done cycle);
    // start while busy is dropped. done is a one-cycle pulse, result/flags hold until the next one.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_nxt;
    logic             load, step, last;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-5:0] asm_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [4:0]       slice_sum;
    logic [WIDTH-1:0] raw, final_res;
    logic             ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (start) begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == RUN);
    assign dbg_state = state;

    // The slice; earlier nibbles sit in asm_r with nibble 0 at the bottom.
    assign slice_sum = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0, carry};
    assign raw       = {slice_sum[3:0], asm_r};
    // Sign-rule overflow on the top nibble, equivalent to carry-in ^ carry-out of the MSB.
    assign ovf       = (a_sh[3] ~^ b_sh[3]) & (slice_sum[3] ^ a_sh[3]);

`ifdef SATURATE_EN
    assign final_res = !ovf    ? raw :
                       a_sh[3] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign final_res = raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            asm_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b1;
            flag_v <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                a_sh  <= A;
                b_sh  <= B ^ {WIDTH{sub}};
                carry <= sub;
                cnt   <= '0;
            end else if (step) begin
                a_sh  <= {4'b0, a_sh[WIDTH-1:4]};
                b_sh  <= {4'b0, b_sh[WIDTH-1:4]};
                asm_r <= raw[WIDTH-1:4];
                carry <= slice_sum[4];
                cnt   <= cnt + 1'b1;
            end
            if (last) begin
                result <= final_res;
                flag_n <= final_res[WIDTH-1];
                flag_z <= (final_res == '0);
                flag_v <= ovf;
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub_16bit.sv
// Directed bench for nibble_serial_addsub_16bit; expectations follow SATURATE_EN when defined.
module tb_nibble_serial_addsub_16bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        busy, done, flag_n, flag_z, flag_v, dbg_state;
    logic [15:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    nibble_serial_addsub_16bit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .busy(busy), .done(done), .result(result),
        .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Driver: present operands with start for one edge; returns at the negedge after acceptance.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Driver: count busy cycles up to done; timed_out set if done never shows within budget.
    task automatic wait_done(output int busy_cycles, output int done_seen, output bit timed_out);
        busy_cycles = 0;
        done_seen   = 0;
        timed_out   = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                done_seen++;
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, flag_n, flag_z, flag_v, dbg_state} !== 6'b000100)
            $display("FAIL reset_ctl: got busy/done/n/z/v/st=%b required 000100",
                     {busy, done, flag_n, flag_z, flag_v, dbg_state});
        else n_pass++;
        n_checks++;
        if (result !== 16'h0000) $display("FAIL reset_result: got %h required 0000", result);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_op(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [15:0] exp_r, input logic [2:0] exp_nzv);
        int cyc, dn;
        bit to;
        start_op(a, b, s);
        wait_done(cyc, dn, to);
        n_checks++;
        if (to) $display("FAIL %s_timeout: got no done required done within 20 cycles", name);
        else n_pass++;
        n_checks++;
        if (cyc !== 4) $display("FAIL %s_latency: got %0d busy cycles required 4", name, cyc);
        else n_pass++;
        n_checks++;
        if (result !== exp_r) $display("FAIL %s_result: got %h required %h", name, result, exp_r);
        else n_pass++;
        n_checks++;
        if ({flag_n, flag_z, flag_v} !== exp_nzv)
            $display("FAIL %s_flags: got nzv=%b required %b", name, {flag_n, flag_z, flag_v}, exp_nzv);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || result !== exp_r)
            $display("FAIL %s_hold: got done=%b result=%h required done=0 result=%h",
                     name, done, result, exp_r);
        else n_pass++;
    endtask

    task automatic test_ignore_and_back_to_back();
        int dn, cyc;
        bit to;
        start_op(16'h00FF, 16'h0001, 1'b0);
        A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        to = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (done) begin
                dn++;
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (to || result !== 16'h0100)
            $display("FAIL ignore_result: got %h timeout=%b required 0100", result, to);
        else n_pass++;
        // Request a new op during the done cycle; it must be accepted at once.
        A = 16'h0003; B = 16'h0004; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept: got busy=%b done=%b required busy=1 done=0", busy, done);
        else n_pass++;
        wait_done(cyc, dn, to);
        n_checks++;
        if (to || cyc !== 4 || result !== 16'h0007)
            $display("FAIL b2b_result: got %h cycles=%0d required 0007 cycles=4", result, cyc);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_abort();
        int seen_done;
        start_op(16'h1111, 16'h1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0000 || flag_z !== 1'b1)
            $display("FAIL abort_state: got busy=%b done=%b result=%h z=%b required 0 0 0000 1",
                     busy, done, result, flag_z);
        else n_pass++;
        seen_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        n_checks++;
        if (seen_done !== 0) $display("FAIL abort_no_done: got %0d done pulses required 0", seen_done);
        else n_pass++;
        test_op("rerun", 16'h1111, 16'h1111, 1'b0, 16'h2222, 3'b000);
    endtask

    initial begin
        test_reset();
        test_op("add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 3'b000);
        test_op("sub_zero", 16'h0005, 16'h0005, 1'b1, 16'h0000, 3'b010);
        test_op("neg_add", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 3'b100);
        test_op("sub_borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 3'b100);
`ifdef SATURATE_EN
        test_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 3'b001);
        test_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 3'b101);
        test_op("sub_minneg", 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 3'b001);
`else
        test_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b101);
        test_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 3'b001);
        test_op("sub_minneg", 16'h0000, 16'h8000, 1'b1, 16'h8000, 3'b101);
`endif
        test_ignore_and_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
